// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: request/grant and TX-command signals between the transmit
// arbiter and its clients (protocol controller, host interface, TX FSM).
//   hs_req/hs_type/hs_grant/hs_done          handshake requester
//   data_req/data_size/buffer_occupancy/
//   data_grant/data_done                     DATA requester
//   tx_packet/tx_packet_data_size/tx_done    TX state machine command path
//   tx_busy/tx_error                         arbiter status
// Modports: slave = arbiter side, master = client/stimulus side.
interface tx_arbiter_if;
  logic       hs_req;
  logic       hs_type;
  logic       hs_grant;
  logic       hs_done;
  logic       data_req;
  logic [6:0] data_size;
  logic [6:0] buffer_occupancy;
  logic       data_grant;
  logic       data_done;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_data_size;
  logic       tx_done;
  logic       tx_busy;
  logic       tx_error;

  modport slave (
    input  hs_req, hs_type, data_req, data_size, buffer_occupancy, tx_done,
    output hs_grant, hs_done, data_grant, data_done, tx_packet,
           tx_packet_data_size, tx_busy, tx_error
  );

  modport master (
    output hs_req, hs_type, data_req, data_size, buffer_occupancy, tx_done,
    input  hs_grant, hs_done, data_grant, data_done, tx_packet,
           tx_packet_data_size, tx_busy, tx_error
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the USB transmit path between the protocol controller
// (ACK/NAK handshakes) and the host interface (DATA packets). Handshakes have
// priority; DATA is held back until the TX buffer holds the whole payload.
// Issues a one-cycle packet command, waits for tx_done, then enforces an
// inter-packet gap of GAP_CYCLES clocks.
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    tx_arbiter_if.slave (requests, grants, TX command, status)
// Parameters:
//   GAP_CYCLES      idle clocks after tx_done/abort before next grant (0 = none)
//   TIMEOUT_CYCLES  WAIT_DONE limit before abort (watchdog builds only)
// Optional feature: define TX_ARBITER_WATCHDOG_EN to enable the WAIT_DONE
// watchdog; otherwise WAIT_DONE waits indefinitely and tx_error stays 0.
module tx_arbiter #(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input logic        clk,
  input logic        n_rst,
  tx_arbiter_if.slave bus
);

  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             owner_data;
  logic             wd_expired;

`ifdef TX_ARBITER_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Expires on the TIMEOUT_CYCLES-th clock spent in WAIT_DONE; the counter
  // stops below TIMEOUT_CYCLES so it can neither saturate nor wrap.
  always_comb begin
    wd_expired = (32'(wd_cnt) + 32'd1 >= TIMEOUT_CYCLES);
  end
`else
  always_comb begin
    wd_expired = 1'b0;
  end

  // TIMEOUT_CYCLES has no effect without the watchdog.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                   <= IDLE;
      gap_cnt                 <= '0;
      owner_data              <= 1'b0;
      bus.hs_grant            <= 1'b0;
      bus.hs_done             <= 1'b0;
      bus.data_grant          <= 1'b0;
      bus.data_done           <= 1'b0;
      bus.tx_packet           <= '0;
      bus.tx_packet_data_size <= '0;
      bus.tx_busy             <= 1'b0;
      bus.tx_error            <= 1'b0;
`ifdef TX_ARBITER_WATCHDOG_EN
      wd_cnt                  <= '0;
`endif
    end else begin
      // Pulse outputs default low; tx_packet is only non-zero in ISSUE.
      bus.hs_grant   <= 1'b0;
      bus.hs_done    <= 1'b0;
      bus.data_grant <= 1'b0;
      bus.data_done  <= 1'b0;
      bus.tx_error   <= 1'b0;
      bus.tx_packet  <= '0;

      case (state)
        IDLE: begin
          if (bus.hs_req) begin
            bus.hs_grant            <= 1'b1;
            bus.tx_packet           <= {1'b1, bus.hs_type};
            bus.tx_packet_data_size <= '0;
            owner_data              <= 1'b0;
            bus.tx_busy             <= 1'b1;
            state                   <= ISSUE;
          end else if (bus.data_req && (bus.buffer_occupancy >= bus.data_size)) begin
            bus.data_grant          <= 1'b1;
            bus.tx_packet           <= 2'b01;
            bus.tx_packet_data_size <= bus.data_size;
            owner_data              <= 1'b1;
            bus.tx_busy             <= 1'b1;
            state                   <= ISSUE;
          end
        end

        ISSUE: begin
`ifdef TX_ARBITER_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          state  <= WAIT_DONE;
        end

        WAIT_DONE: begin
          // tx_done takes precedence over a simultaneous watchdog expiry.
          if (bus.tx_done || wd_expired) begin
            if (bus.tx_done) begin
              bus.hs_done   <= ~owner_data;
              bus.data_done <= owner_data;
            end else begin
              bus.tx_error  <= 1'b1;
            end
            if (GAP_CYCLES == 0) begin
              bus.tx_busy <= 1'b0;
              state       <= IDLE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end
          end else begin
`ifdef TX_ARBITER_WATCHDOG_EN
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end

        GAP: begin
          // Leaving on the edge that takes the count to zero keeps GAP
          // exactly GAP_CYCLES clocks long.
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt     <= '0;
            bus.tx_busy <= 1'b0;
            state       <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          bus.tx_busy <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
